// File: rtl/smbus_level_fifo.sv
// smbus_level_fifo: synchronous FIFO for the SMBus TX/RX data paths with FWFT or
// registered read, live almost-full/almost-empty thresholds, sticky errors and a high-water mark.
module smbus_level_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 32,
  parameter  int READ_MODE  = 0,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic [CW-1:0]         af_thresh,
  input  logic [CW-1:0]         ae_thresh,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         hwm,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_next;
  logic [CW-1:0]         r_hwm;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  // Acceptance uses start-of-cycle full/empty: no write-through-read or read-through-write.
  assign w_wr_acc = wr_en && !w_full && !flush;
  assign w_rd_acc = rd_en && !w_empty && !flush;

  always_comb begin
    w_count_next = r_count;
    if (flush)
      w_count_next = '0;
    else if (w_wr_acc && !w_rd_acc)
      w_count_next = r_count + CW'(1);
    else if (w_rd_acc && !w_wr_acc)
      w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst)
      r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hwm       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_acc)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_next;
      // Loading the post-update count keeps hwm >= count even when a write coincides.
      if (clr_err || (w_count_next > r_hwm))
        r_hwm <= w_count_next;
      r_overflow  <= (r_overflow && !clr_err) || (wr_en && w_full);
      r_underflow <= (r_underflow && !clr_err) || (rd_en && w_empty);
    end
  end

  generate
    if (READ_MODE == 1) begin : g_reg_read
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (w_rd_acc) begin
          r_rd_data  <= r_mem[r_rd_ptr];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end else begin : g_fwft_read
      assign rd_data  = r_mem[r_rd_ptr];
      assign rd_valid = !w_empty;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign count        = r_count;
  assign hwm          = r_hwm;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_smbus_level_fifo.sv
// tb_smbus_level_fifo: drives an FWFT and a registered-read instance with identical stimulus
// and compares both against a queue-based scoreboard of FIFO contents, flags and errors.
module tb_smbus_level_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, flush, clr_err;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] af_thresh, ae_thresh;

  logic [DW-1:0] a_rd_data, b_rd_data;
  logic          a_rd_valid, b_rd_valid;
  logic          a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic          b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [CW-1:0] a_count, a_hwm, b_count, b_hwm;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_q[$];
  logic          m_ovf, m_udf, m_rv;
  int            m_hwm;
  logic [DW-1:0] m_b_data;

  always #5 clk = ~clk;

  smbus_level_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_MODE(0)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .flush(flush), .clr_err(clr_err),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .hwm(a_hwm),
    .overflow(a_ovf), .underflow(a_udf)
  );

  smbus_level_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_MODE(1)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .flush(flush), .clr_err(clr_err),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count), .hwm(b_hwm),
    .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int cnt;
    cnt = m_q.size();
    check("a_count",  32'(a_count), 32'(cnt));
    check("b_count",  32'(b_count), 32'(cnt));
    check("a_full",   32'(a_full),  32'(cnt == DEPTH));
    check("b_full",   32'(b_full),  32'(cnt == DEPTH));
    check("a_empty",  32'(a_empty), 32'(cnt == 0));
    check("b_empty",  32'(b_empty), 32'(cnt == 0));
    check("a_afull",  32'(a_af),    32'(cnt >= int'(af_thresh)));
    check("b_afull",  32'(b_af),    32'(cnt >= int'(af_thresh)));
    check("a_aempty", 32'(a_ae),    32'(cnt <= int'(ae_thresh)));
    check("b_aempty", 32'(b_ae),    32'(cnt <= int'(ae_thresh)));
    check("a_ovf",    32'(a_ovf),   32'(m_ovf));
    check("b_ovf",    32'(b_ovf),   32'(m_ovf));
    check("a_udf",    32'(a_udf),   32'(m_udf));
    check("b_udf",    32'(b_udf),   32'(m_udf));
    check("a_hwm",    32'(a_hwm),   32'(m_hwm));
    check("b_hwm",    32'(b_hwm),   32'(m_hwm));
    check("a_rvalid", 32'(a_rd_valid), 32'(cnt != 0));
    check("b_rvalid", 32'(b_rd_valid), 32'(m_rv));
    check("b_rdata",  32'(b_rd_data),  32'(m_b_data));
  endtask

  task automatic do_reset(input logic wr);
    rst = 1'b1; wr_en = wr; wr_data = 8'h99; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_hwm = 0; m_rv = 1'b0; m_b_data = '0;
    $display("reset    count=%0d empty=%0b", a_count, a_empty);
    check_state();
  endtask

  task automatic cycle(input logic wr, input logic [DW-1:0] wd, input logic rd,
                       input logic fl, input logic ce);
    int   cnt;
    logic wa, ra;
    wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; clr_err = ce;
    cnt = m_q.size();
    wa  = wr && !fl && (cnt < DEPTH);
    ra  = rd && !fl && (cnt > 0);
    if (ra)
      check("a_rdata", 32'(a_rd_data), 32'(m_q[0]));
    @(posedge clk); #1;
    if (fl) begin
      m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_hwm = 0; m_rv = 1'b0;
    end else begin
      if (ra) m_b_data = m_q.pop_front();
      if (wa) m_q.push_back(wd);
      m_ovf = (m_ovf && !ce) || (wr && cnt == DEPTH);
      m_udf = (m_udf && !ce) || (rd && cnt == 0);
      if (ce || m_q.size() > m_hwm) m_hwm = m_q.size();
      m_rv = ra;
    end
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    $display("cycle wr=%0b d=%02h rd=%0b fl=%0b ce=%0b -> count=%0d b_rd=%02h/%0b",
             wr, wd, rd, fl, ce, a_count, b_rd_data, b_rd_valid);
    check_state();
  endtask

  initial begin
    af_thresh = 3'd3; ae_thresh = 3'd1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0; wr_data = '0; rst = 1'b1;

    do_reset(1'b1);

    // Fill, overflow attempt, then threshold boundaries at full.
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    cycle(1, 8'h44, 0, 0, 0);
    cycle(1, 8'h55, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    af_thresh = 3'd5; ae_thresh = 3'd4; #1; check_state();
    af_thresh = 3'd4; ae_thresh = 3'd3; #1; check_state();
    af_thresh = 3'd3; ae_thresh = 3'd1; #1;

    // Drain in order, then read while empty.
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1);

    // Simultaneous read/write at count 2 across pointer wrap.
    cycle(1, 8'hAA, 0, 0, 0);
    cycle(1, 8'hBB, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'hC0 + i), 1, 0, 0);

    // Simultaneous at full: write rejected.
    cycle(1, 8'hD0, 0, 0, 0);
    cycle(1, 8'hD1, 0, 0, 0);
    cycle(1, 8'hD2, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1);

    // Simultaneous at empty: read rejected.
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 0);
    cycle(1, 8'hE0, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    // Registered read: data appears next cycle and holds afterwards.
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    // Flush beats a same-cycle write and clears errors.
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h60 + i), 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(1, 8'hEE, 0, 1, 0);
    cycle(1, 8'h12, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    // Reset in the middle of a write burst.
    cycle(1, 8'h81, 0, 0, 0);
    cycle(1, 8'h82, 0, 0, 0);
    do_reset(1'b1);
    cycle(1, 8'h77, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
